// File: rtl/shift_sequencer_if.sv
// Command/result bundle between the ALU issue logic and the shift sequencer.
// The issue side is the master; the sequencer is the slave.
interface shift_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] operand;
    logic [3:0]  amount;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        zero;

    modport master (
        output start, op, operand, amount,
        input  busy, done, result, carry, zero
    );

    modport slave (
        input  start, op, operand, amount,
        output busy, done, result, carry, zero
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-pass 16-bit shift/rotate unit built around a single left-only barrel shifter.
// Right shifts reverse bits around the shifter; SAR and ROL merge a second pass into the accumulator.
//
// state  | meaning
// IDLE   | waiting for start (ignored while the done pulse is out)
// P1     | first shifter pass; SHL/SHR finish here, SAR/ROL fill the accumulator
// P2     | second pass merged with the accumulator (SAR fill, ROL wrap-around)
// DONE   | result registered; done pulse follows in the next cycle
module shift_sequencer (
    input  logic             clk,
    input  logic             rst,
    shift_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_P1   = 2'd1;
    localparam logic [1:0] S_P2   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_SHL = 2'd0;
    localparam logic [1:0] OP_SHR = 2'd1;
    localparam logic [1:0] OP_SAR = 2'd2;
    localparam logic [1:0] OP_ROL = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] operand_q, operand_d;
    logic [3:0]  amount_q, amount_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic        done_q, done_d;

    logic [15:0] sh_in, sh_out;
    logic [3:0]  sh_amt;
    logic        right_op;
    logic [15:0] pass1, pass2, res_new;
    logic        carry_new, wr_result;

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    assign right_op = (op_q == OP_SHR) || (op_q == OP_SAR);

    // The one shared shifter; its inputs are steered by the current pass.
    assign sh_out = sh_in << sh_amt;

    always_comb begin
        sh_in  = operand_q;
        sh_amt = amount_q;
        if (state_q == S_P2) begin
            if (op_q == OP_SAR) begin
                sh_in = 16'hFFFF;
            end else begin
                sh_in  = rev16(operand_q);
                sh_amt = 4'd0 - amount_q;
            end
        end else if (right_op) begin
            sh_in = rev16(operand_q);
        end
    end

    assign pass1 = right_op ? rev16(sh_out) : sh_out;
    assign pass2 = (op_q == OP_SAR) ? (acc_q | (operand_q[15] ? ~rev16(sh_out) : 16'h0000))
                                    : (acc_q | rev16(sh_out));

    always_comb begin
        carry_new = 1'b0;
        if (amount_q != 4'd0) begin
            case (op_q)
                OP_SHL:  carry_new = operand_q[4'd0 - amount_q];
                OP_ROL:  carry_new = res_new[0];
                default: carry_new = operand_q[amount_q - 4'd1];
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        amount_d  = amount_q;
        acc_d     = acc_q;
        res_new   = pass1;
        wr_result = 1'b0;
        done_d    = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (bus.start && !done_q) begin
                    op_d      = bus.op;
                    operand_d = bus.operand;
                    amount_d  = bus.amount;
                    state_d   = S_P1;
                end
            end
            S_P1: begin
                if (op_q == OP_SHL || op_q == OP_SHR) begin
                    wr_result = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    acc_d   = pass1;
                    state_d = S_P2;
                end
            end
            S_P2: begin
                res_new   = pass2;
                wr_result = 1'b1;
                state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        result_d = wr_result ? res_new : result_q;
        carry_d  = wr_result ? carry_new : carry_q;
        zero_d   = wr_result ? (res_new == 16'h0000) : zero_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 2'd0;
            operand_q <= 16'h0000;
            amount_q  <= 4'd0;
            acc_q     <= 16'h0000;
            result_q  <= 16'h0000;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            amount_q  <= amount_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
        end
    end

    // Busy stays up through the done cycle so a new start can only land afterwards.
    assign bus.busy   = (state_q != S_IDLE) || done_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
endmodule
